// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the shared-ALU scheduler.
//   op_t     - 3-bit ALU opcode
//   state_t  - scheduler FSM state
//   FLAG_*   - bit positions of N/Z/C/V inside the 4-bit flag vector {N,Z,C,V}
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU with N/Z/C/V flag generation.
// Ports:
//   a, b    in  WIDTH  operands
//   op      in  3      opcode (alu_pkg::op_t encoding)
//   result  out WIDTH  result, modulo 2^WIDTH
//   flags   out 4      {N,Z,C,V}
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b unsigned.
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_PASS: result = a;
      default: result = a;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter sharing one alu_core between NREQ requesters.
// An accepted op is captured in IDLE, executed in EXEC, and its result held in RESP
// until the consumer takes it (one op per 3 cycles at best).
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester handshake; req_ready is a one-hot grant
//   req_a/req_b/req_op        packed per-requester operands and opcodes
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_result/rsp_flags  issuing requester, result, {N,Z,C,V}
// Optional build macro ALU_STICKY_FLAGS_EN adds:
//   flags_clr     in  1  clears the sticky flag accumulator
//   sticky_flags  out 4  OR of flags of every executed op since last clear/reset
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic                  flags_clr,
  output logic [3:0]            sticky_flags
`endif
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic [2:0]       cap_op_q, cap_op_d;
  logic [IDW-1:0]   cap_id_q, cap_id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand_id;
  int unsigned      cand;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (cap_a_q),
    .b      (cap_b_q),
    .op     (cap_op_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // First valid requester at or after the pointer, scanning cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    cand_id     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand    = (32'(ptr_q) + i) % NREQ;
      cand_id = IDW'(cand);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    cap_op_d     = cap_op_q;
    cap_id_d     = cap_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset forces IDLE asynchronously; masking keeps the grant low while it is held.
        if (grant_found && !reset) begin
          req_ready = NREQ'(1) << grant_id;
          cap_a_d   = req_a[grant_id*WIDTH +: WIDTH];
          cap_b_d   = req_b[grant_id*WIDTH +: WIDTH];
          cap_op_d  = req_op[grant_id*3 +: 3];
          cap_id_d  = grant_id;
          ptr_d     = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d     = cap_id_q;
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cap_a_q      <= '0;
      cap_b_q      <= '0;
      cap_op_q     <= '0;
      cap_id_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      cap_op_q     <= cap_op_d;
      cap_id_q     <= cap_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // Clear applies first so flags from a coincident EXEC edge survive the clear.
  always_comb begin
    sticky_d = flags_clr ? 4'b0000 : sticky_q;
    if (state_q == EXEC) sticky_d = sticky_d | alu_flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed self-checking bench for alu_scheduler (WIDTH=4, NREQ=4).
module tb_alu_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic [3:0]  rsp_flags;
`ifdef ALU_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [3:0]  sticky_flags;
`endif

  int checks = 0;
  int errors = 0;

  alu_scheduler #(.WIDTH(4), .NREQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op);
    req_a[idx*4 +: 4]  = a;
    req_b[idx*4 +: 4]  = b;
    req_op[idx*3 +: 3] = op;
  endtask

  // One full transaction from a single requester with rsp_ready=1.
  task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] er, input logic [3:0] ef);
    int n;
    set_lane(idx, a, b, op);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    n = 0;
    while (!req_ready[idx] && n < 8) begin
      tick();
      n++;
    end
    chk("grant", 32'(req_ready), 32'(4'b0001 << idx));
    tick();
    req_valid = '0;
    chk("exec_no_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(idx));
    chk("rsp_result", 32'(rsp_result), 32'(er));
    chk("rsp_flags", 32'(rsp_flags), 32'(ef));
    tick();
    chk("after_hs", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_res [4];
    logic [3:0] exp_flg [4];

    reset     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
`ifdef ALU_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    reset = 1'b0;
    #1;
    chk("first_grant_req0", 32'(req_ready), 32'b0001);

    // ADD 7+9 wraps to 0: Z,C
    do_op(0, 4'd7, 4'd9, 3'd0, 4'd0, 4'b0110);
    // SUB 3-5 = 14: N,C(borrow)
    do_op(2, 4'd3, 4'd5, 3'd1, 4'd14, 4'b1010);
    // ADD 7+1 = 8: N,V
    do_op(1, 4'd7, 4'd1, 3'd0, 4'd8, 4'b1001);
`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_accum", 32'(sticky_flags), 32'b1111);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("sticky_clr", 32'(sticky_flags), 32'd0);
`endif
    // XOR 5^3 = 6, no flags; leaves pointer at 0
    do_op(3, 4'd5, 4'd3, 3'd4, 4'd6, 4'b0000);

    // Round robin, all valid continuously
    set_lane(0, 4'd1, 4'd2, 3'd0);    exp_res[0] = 4'd3; exp_flg[0] = 4'b0000;
    set_lane(1, 4'd5, 4'd5, 3'd1);    exp_res[1] = 4'd0; exp_flg[1] = 4'b0100;
    set_lane(2, 4'd12, 4'd10, 3'd2);  exp_res[2] = 4'd8; exp_flg[2] = 4'b1000;
    set_lane(3, 4'd1, 4'd4, 3'd3);    exp_res[3] = 4'd5; exp_flg[3] = 4'b0000;
    req_valid = 4'b1111;
    for (int e = 1; e <= 14; e++) begin
      tick();
      chk("rr_valid", 32'(rsp_valid), (e % 3 == 2) ? 32'd1 : 32'd0);
      if (e % 3 == 2) begin
        chk("rr_id", 32'(rsp_id), 32'(((e - 2) / 3) % 4));
        chk("rr_result", 32'(rsp_result), 32'(exp_res[((e - 2) / 3) % 4]));
        chk("rr_flags", 32'(rsp_flags), 32'(exp_flg[((e - 2) / 3) % 4]));
      end
    end
    req_valid = '0;
    tick();
    chk("rr_done", 32'(rsp_valid), 32'd0);

    // Backpressure: SHR 5 = 2, C=a[0]
    set_lane(1, 4'd5, 4'd0, 3'd6);
    set_lane(2, 4'd9, 4'd0, 3'd7);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0100;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_result", 32'(rsp_result), 32'd2);
      chk("bp_flags", 32'(rsp_flags), 32'b0010);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    // PASS 9: N
    do_op(2, 4'd9, 4'd0, 3'd7, 4'd9, 4'b1000);

    // Reset during EXEC of req3 SHL 9
    set_lane(3, 4'd9, 4'd0, 3'd5);
    req_valid = 4'b1000;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_rsp_result", 32'(rsp_result), 32'd0);
    chk("midrst_rsp_flags", 32'(rsp_flags), 32'd0);
`ifdef ALU_STICKY_FLAGS_EN
    chk("midrst_sticky", 32'(sticky_flags), 32'd0);
`endif
    reset = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("midrst_grant_req0", 32'(req_ready), 32'b0001);
    // SUB 2-1 = 1
    do_op(0, 4'd2, 4'd1, 3'd1, 4'd1, 4'b0000);
    // SHL 9 = 2, C=a[3]
    do_op(3, 4'd9, 4'd0, 3'd5, 4'd2, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
